// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    typedef enum logic [2:0] {
        WAIT_CS,
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;

    localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises sclk/mosi/cs_n into the clk domain and derives sclk edge events.
// Pin-to-event latency is SYNC_STAGES+1 clk cycles; mosi and cs_n are delayed
// by the same amount so they line up with the events.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_cs_n,
    output logic o_rise_evt,
    output logic o_fall_evt,
    output logic o_mosi,
    output logic o_cs_n
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_mosi_d;
    logic                   r_cs_d;

    // Synchroniser chains and edge detection; left unreset so a reset taken
    // mid-frame still sees the true cs_n level when it is released.
    always_ff @(posedge i_clk) begin
        r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
        r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        r_rise      <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
        r_fall      <= ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
        r_mosi_d    <= r_mosi_sync[SYNC_STAGES-1];
        r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end

    assign o_rise_evt = r_rise;
    assign o_fall_evt = r_fall;
    assign o_mosi     = r_mosi_d;
    assign o_cs_n     = r_cs_d;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-3 responder: 16-bit frames {rw, addr[6:0], data[7:0]}.
// Exports command and write strobes; shifts user read data out on miso.
module spi_responder
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        MISO_IDLE   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                cs_n,
    output logic                miso,
    output logic                miso_oe,
    output logic                cmd_valid,
    output logic                cmd_rw,
    output logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                wr_valid,
    output logic [DATA_W-1:0]   wr_data,
    output logic                frame_err
);

    localparam logic [3:0] CMD_LAST   = 4'(FRAME_BITS - DATA_W - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

    logic w_rise;
    logic w_fall;
    logic w_mosi;
    logic w_cs_n;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [DATA_W-2:0]   r_rx, w_rx_nxt;
    logic [DATA_W-1:0]   r_tx, w_tx_nxt;
    logic                r_tx_loaded, w_tx_loaded_nxt;
    logic                r_miso, w_miso_nxt;
    logic                r_miso_oe, w_miso_oe_nxt;
    logic                r_cmd_valid, w_cmd_valid_nxt;
    logic                r_cmd_rw, w_cmd_rw_nxt;
    logic [ADDR_W-1:0]   r_cmd_addr, w_cmd_addr_nxt;
    logic                r_wr_valid, w_wr_valid_nxt;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
    logic                r_frame_err, w_frame_err_nxt;
    logic [DATA_W-1:0]   w_rx_byte;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk      (clk),
        .i_sclk     (sclk),
        .i_mosi     (mosi),
        .i_cs_n     (cs_n),
        .o_rise_evt (w_rise),
        .o_fall_evt (w_fall),
        .o_mosi     (w_mosi),
        .o_cs_n     (w_cs_n)
    );

    // Byte completed by the current rise event.
    assign w_rx_byte = {r_rx, w_mosi};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= WAIT_CS;
        else      r_state <= w_state_nxt;
    end

    // Next-state, shift/count and output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rx_nxt        = r_rx;
        w_tx_nxt        = r_tx;
        w_tx_loaded_nxt = r_tx_loaded;
        w_miso_nxt      = r_miso;
        w_miso_oe_nxt   = r_miso_oe;
        w_cmd_rw_nxt    = r_cmd_rw;
        w_cmd_addr_nxt  = r_cmd_addr;
        w_wr_data_nxt   = r_wr_data;
        w_cmd_valid_nxt = 1'b0;
        w_wr_valid_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            WAIT_CS: begin
                if (w_cs_n) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (!w_cs_n) begin
                    w_miso_oe_nxt   = 1'b1;
                    w_miso_nxt      = MISO_IDLE;
                    w_cnt_nxt       = '0;
                    w_tx_loaded_nxt = 1'b0;
                    w_state_nxt     = CMD;
                end
            end
            CMD: begin
                if (w_cs_n) begin
                    w_frame_err_nxt = 1'b1;
                    w_miso_oe_nxt   = 1'b0;
                    w_miso_nxt      = MISO_IDLE;
                    w_state_nxt     = IDLE;
                end else begin
                    if (w_fall) w_miso_nxt = 1'b0;
                    if (w_rise) begin
                        w_rx_nxt  = w_rx_byte[DATA_W-2:0];
                        w_cnt_nxt = r_cnt + 4'd1;
                        if (r_cnt == CMD_LAST) begin
                            w_cmd_rw_nxt    = w_rx_byte[DATA_W-1];
                            w_cmd_addr_nxt  = w_rx_byte[ADDR_W-1:0];
                            w_cmd_valid_nxt = 1'b1;
                            w_state_nxt     = DATA;
                        end
                    end
                end
            end
            DATA: begin
                // The last rise wins over a simultaneous cs_n release.
                if (w_rise && r_cnt == FRAME_LAST) begin
                    if (r_cmd_rw != RW_READ) begin
                        w_wr_data_nxt  = w_rx_byte;
                        w_wr_valid_nxt = 1'b1;
                    end
                    w_state_nxt = DONE;
                end else if (w_cs_n) begin
                    w_frame_err_nxt = 1'b1;
                    w_miso_oe_nxt   = 1'b0;
                    w_miso_nxt      = MISO_IDLE;
                    w_state_nxt     = IDLE;
                end else begin
                    if (w_rise) begin
                        w_rx_nxt  = w_rx_byte[DATA_W-2:0];
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                    if (w_fall) begin
                        if (!r_tx_loaded) begin
                            w_tx_loaded_nxt = 1'b1;
                            w_tx_nxt        = {rd_data[DATA_W-2:0], 1'b0};
                            w_miso_nxt      = (r_cmd_rw == RW_READ) ? rd_data[DATA_W-1] : 1'b0;
                        end else begin
                            w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                            w_miso_nxt = (r_cmd_rw == RW_READ) ? r_tx[DATA_W-1] : 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                if (w_cs_n) begin
                    w_miso_oe_nxt = 1'b0;
                    w_miso_nxt    = MISO_IDLE;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = WAIT_CS;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_tx_loaded <= 1'b0;
            r_miso      <= MISO_IDLE;
            r_miso_oe   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_rw    <= 1'b0;
            r_cmd_addr  <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_rx        <= w_rx_nxt;
            r_tx        <= w_tx_nxt;
            r_tx_loaded <= w_tx_loaded_nxt;
            r_miso      <= w_miso_nxt;
            r_miso_oe   <= w_miso_oe_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_cmd_rw    <= w_cmd_rw_nxt;
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_wr_valid  <= w_wr_valid_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_miso_oe;
    assign cmd_valid = r_cmd_valid;
    assign cmd_rw    = r_cmd_rw;
    assign cmd_addr  = r_cmd_addr;
    assign wr_valid  = r_wr_valid;
    assign wr_data   = r_wr_data;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: directed frame table, hand-built corner sequences
// and randomised frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b1;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic       miso_oe;
    logic       cmd_valid;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       frame_err;

    always #5 clk = ~clk;

    spi_responder #(
        .SYNC_STAGES(2),
        .MISO_IDLE  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .cmd_valid (cmd_valid),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .rd_data   (rd_data),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [7:0]  rd;
        int          half;
        int          rst_bit;
        bit          simul;
        int          exp_ncmd;
        logic        exp_rw;
        logic [6:0]  exp_addr;
        int          exp_nwr;
        logic [7:0]  exp_wr;
        int          exp_err;
        bit          chk_miso;
        logic [7:0]  exp_miso2;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Strobe monitor: counts high cycles of each strobe and captures payloads.
    int         n_cmd = 0;
    int         n_wr  = 0;
    int         n_err = 0;
    logic       cap_rw;
    logic [6:0] cap_addr;
    logic [7:0] cap_wr;

    always @(negedge clk) begin
        if (cmd_valid) begin
            n_cmd++;
            cap_rw   = cmd_rw;
            cap_addr = cmd_addr;
        end
        if (wr_valid) begin
            n_wr++;
            cap_wr = wr_data;
        end
        if (frame_err) n_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: what a frame of nb clocked bits must produce.
    function automatic vec_t model(input logic [15:0] f, input int nb,
                                   input logic [7:0] rd, input int half);
        vec_t v;
        v.frame     = f;
        v.nbits     = nb;
        v.rd        = rd;
        v.half      = half;
        v.rst_bit   = -1;
        v.simul     = 1'b0;
        v.exp_ncmd  = (nb >= 8) ? 1 : 0;
        v.exp_rw    = f[15];
        v.exp_addr  = f[14:8];
        v.exp_nwr   = (nb >= 16 && !f[15]) ? 1 : 0;
        v.exp_wr    = f[7:0];
        v.exp_err   = (nb < 16) ? 1 : 0;
        v.chk_miso  = 1'b1;
        v.exp_miso2 = f[15] ? rd : 8'h00;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] samp;
        logic [15:0] mask;
        logic [15:0] expm;
        logic        extra_bad;
        int          oe_bad;
        bit          post_rst;
        int          nb;
        samp      = '0;
        mask      = '0;
        expm      = {8'h00, v.exp_miso2};
        extra_bad = 1'b0;
        oe_bad    = 0;
        post_rst  = 1'b0;
        n_cmd = 0;
        n_wr  = 0;
        n_err = 0;
        rd_data = v.rd;
        cs_n = 1'b0;
        repeat (v.half) @(posedge clk);
        #1;
        for (int i = 0; i < v.nbits; i++) begin
            sclk = 1'b0;
            mosi = (i < 16) ? v.frame[15-i] : 1'($urandom);
            repeat (v.half) @(posedge clk);
            #1;
            if (i == v.rst_bit) begin
                rst = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk({tag, " rst_miso"}, miso, 1);
                chk({tag, " rst_oe"}, miso_oe, 0);
                chk({tag, " rst_strobes"}, {cmd_valid, wr_valid, frame_err}, 0);
                rst = 1'b1;
                post_rst = 1'b1;
            end
            if (i < 16) samp[15-i] = miso;
            else if (miso !== expm[0]) extra_bad = 1'b1;
            if (!post_rst && miso_oe !== 1'b1) oe_bad++;
            sclk = 1'b1;
            if (v.simul && i == v.nbits - 1) cs_n = 1'b1;
            repeat (v.half) @(posedge clk);
            #1;
        end
        cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk({tag, " idle_oe"}, miso_oe, 0);
        chk({tag, " idle_miso"}, miso, 1);
        repeat (4 * v.half) @(posedge clk);
        #1;
        chk({tag, " n_cmd_valid"}, n_cmd, v.exp_ncmd);
        if (v.exp_ncmd > 0) begin
            chk({tag, " cmd_rw"}, cap_rw, v.exp_rw);
            chk({tag, " cmd_addr"}, cap_addr, v.exp_addr);
        end
        chk({tag, " n_wr_valid"}, n_wr, v.exp_nwr);
        if (v.exp_nwr > 0) chk({tag, " wr_data"}, cap_wr, v.exp_wr);
        chk({tag, " n_frame_err"}, n_err, v.exp_err);
        chk({tag, " oe_in_frame_bad"}, oe_bad, 0);
        nb = (v.nbits < 16) ? v.nbits : 16;
        if (v.chk_miso && nb > 0) begin
            for (int i = 0; i < nb; i++) mask[15-i] = 1'b1;
            chk({tag, " miso_bits"}, samp & mask, expm & mask);
            if (v.nbits > 16) chk({tag, " miso_hold"}, extra_bad, 0);
        end
    endtask

    vec_t vecs[8];
    vec_t hv;

    initial begin
        // frame, nbits, rd, half, rst_bit, simul, ncmd, rw, addr, nwr, wr, err, chk_miso, miso2
        vecs[0] = '{16'h2D02, 16, 8'h00, 510, -1, 1'b0, 1, 1'b0, 7'h2D, 1, 8'h02, 0, 1'b1, 8'h00};
        vecs[1] = '{16'h8E00, 16, 8'hAD,  25, -1, 1'b0, 1, 1'b1, 7'h0E, 0, 8'h00, 0, 1'b1, 8'hAD};
        vecs[2] = '{16'h3355, 10, 8'h00,  25, -1, 1'b0, 1, 1'b0, 7'h33, 0, 8'h00, 1, 1'b1, 8'h00};
        vecs[3] = '{16'h1144, 16, 8'h00,  25, -1, 1'b0, 1, 1'b0, 7'h11, 1, 8'h44, 0, 1'b1, 8'h00};
        vecs[4] = '{16'h0111, 16, 8'h00,  20, -1, 1'b0, 1, 1'b0, 7'h01, 1, 8'h11, 0, 1'b1, 8'h00};
        vecs[5] = '{16'h0222, 16, 8'h00,  20, -1, 1'b0, 1, 1'b0, 7'h02, 1, 8'h22, 0, 1'b1, 8'h00};
        vecs[6] = '{16'h4C5A, 20, 8'h00,  20, -1, 1'b0, 1, 1'b0, 7'h4C, 1, 8'h5A, 0, 1'b1, 8'h00};
        vecs[7] = '{16'hC3F0, 20, 8'h5B,  20, -1, 1'b0, 1, 1'b1, 7'h43, 0, 8'h00, 0, 1'b1, 8'h5B};

        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset miso", miso, 1);
        chk("reset miso_oe", miso_oe, 0);
        chk("reset strobes", {cmd_valid, wr_valid, frame_err}, 0);
        chk("reset cmd_rw", cmd_rw, 0);
        chk("reset cmd_addr", cmd_addr, 0);
        chk("reset wr_data", wr_data, 0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Reset during bit 5 with cs_n still low: rest of the frame is dropped.
        hv = '{16'h5A5A, 16, 8'h00, 20, 4, 1'b0, 0, 1'b0, 7'h00, 0, 8'h00, 0, 1'b0, 8'h00};
        run_vec(hv, "midrst");
        hv = '{16'h0A7F, 16, 8'h00, 20, -1, 1'b0, 1, 1'b0, 7'h0A, 1, 8'h7F, 0, 1'b1, 8'h00};
        run_vec(hv, "after_rst");

        // cs_n released together with the 16th rising sclk edge.
        hv = '{16'h2277, 16, 8'h00, 20, -1, 1'b1, 1, 1'b0, 7'h22, 1, 8'h77, 0, 1'b1, 8'h00};
        run_vec(hv, "simul_cs");

        for (int k = 0; k < 24; k++) begin
            logic [15:0] f;
            logic [7:0]  rd;
            int          nb;
            f  = 16'($urandom);
            rd = 8'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            hv = model(f, nb, rd, int'($urandom_range(10, 30)));
            run_vec(hv, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
